// File: rtl/worker_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : worker_scheduler
//  Purpose  : Shares a pool of NUM_WORKERS workers between one packet stream
//             and one result stream. Packets from the packet constructor are
//             buffered and handed to one idle worker, chosen round-robin.
//             Worker results are arbitrated round-robin into a single stream
//             toward the write-back stage.
//  Ports    : clk, rst                - clock (rising edge), async active-high reset
//             receive_pc_*            - packet input stream (valid/ready/data)
//             send_w_valid/ready      - one-hot packet offer / per-worker ready
//             send_w_data             - buffered packet, broadcast to all workers
//             receive_w_valid/ready   - per-worker result valid / one-hot accept
//             receive_w_data          - worker i result at [i*WRW +: WRW]
//             send_wr_*               - result output stream (valid/ready/data)
//  Revision : 1.0 - initial release
// ============================================================================
module worker_scheduler #(
  parameter int PACKET_WIDTH        = 32,
  parameter int WORKER_RESULT_WIDTH = 32,
  parameter int NUM_WORKERS         = 4,
  parameter int PTR_WIDTH           = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       receive_pc_valid,
  output logic                                       receive_pc_ready,
  input  logic [PACKET_WIDTH-1:0]                    receive_pc_data,
  output logic [NUM_WORKERS-1:0]                     send_w_valid,
  input  logic [NUM_WORKERS-1:0]                     send_w_ready,
  output logic [PACKET_WIDTH-1:0]                    send_w_data,
  input  logic [NUM_WORKERS-1:0]                     receive_w_valid,
  output logic [NUM_WORKERS-1:0]                     receive_w_ready,
  input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] receive_w_data,
  output logic                                       send_wr_valid,
  input  logic                                       send_wr_ready,
  output logic [WORKER_RESULT_WIDTH-1:0]             send_wr_data
);

  localparam logic [1:0] D_INIT  = 2'd0;
  localparam logic [1:0] D_EMPTY = 2'd1;
  localparam logic [1:0] D_PICK  = 2'd2;
  localparam logic [1:0] D_SEND  = 2'd3;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_OUT   = 1'b1;

  localparam logic [PTR_WIDTH:0]   c_NUM_W = (PTR_WIDTH+1)'(NUM_WORKERS);
  localparam logic [NUM_WORKERS-1:0] c_ONE = NUM_WORKERS'(1);

  // Round-robin search: returns {found, index} of the first set request bit
  // at or above ptr, wrapping past the last worker back to worker 0.
  // Scanning downward lets the lowest rotated offset win.
  function automatic logic [PTR_WIDTH:0] rr_pick(input logic [NUM_WORKERS-1:0] req,
                                                 input logic [PTR_WIDTH-1:0]   ptr);
    logic [2*NUM_WORKERS-1:0] rot;
    logic [PTR_WIDTH:0]       sum;
    rot     = {req, req} >> ptr;
    sum     = '0;
    rr_pick = '0;
    for (int k = NUM_WORKERS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (PTR_WIDTH+1)'(k);
        if (sum >= c_NUM_W) sum = sum - c_NUM_W;
        rr_pick = {1'b1, sum[PTR_WIDTH-1:0]};
      end
    end
  endfunction

  // (ptr + 1) mod NUM_WORKERS
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    logic [PTR_WIDTH:0] sum;
    sum = {1'b0, ptr} + (PTR_WIDTH+1)'(1);
    if (sum >= c_NUM_W) sum = '0;
    return sum[PTR_WIDTH-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Dispatch side
  // --------------------------------------------------------------------------
  logic [1:0]               r_d_state, w_d_next;
  logic [PACKET_WIDTH-1:0]  r_pkt_buf;
  logic [PTR_WIDTH-1:0]     r_tgt, r_disp_ptr;
  logic [PTR_WIDTH:0]       w_disp_pick;
  logic                     w_disp_found;
  logic [PTR_WIDTH-1:0]     w_disp_idx;
  logic [NUM_WORKERS-1:0]   w_tgt_onehot;
  logic                     w_tgt_accept;

  assign w_disp_pick  = rr_pick(send_w_ready, r_disp_ptr);
  assign w_disp_found = w_disp_pick[PTR_WIDTH];
  assign w_disp_idx   = w_disp_pick[PTR_WIDTH-1:0];
  assign w_tgt_onehot = c_ONE << r_tgt;
  // Only the chosen worker's ready matters once the offer is up.
  assign w_tgt_accept = |(send_w_ready & w_tgt_onehot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_d_state <= D_INIT;
    else     r_d_state <= w_d_next;
  end

  always_comb begin
    w_d_next = r_d_state;
    case (r_d_state)
      D_INIT:  w_d_next = D_EMPTY;
      D_EMPTY: if (receive_pc_valid) w_d_next = D_PICK;
      D_PICK:  if (w_disp_found)     w_d_next = D_SEND;
      D_SEND:  if (w_tgt_accept)     w_d_next = D_EMPTY;
      default: w_d_next = D_INIT;
    endcase
  end

  always_comb begin
    receive_pc_ready = (r_d_state == D_EMPTY);
    send_w_valid     = (r_d_state == D_SEND) ? w_tgt_onehot : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_buf  <= '0;
      r_tgt      <= '0;
      r_disp_ptr <= '0;
    end else begin
      if (r_d_state == D_EMPTY && receive_pc_valid) r_pkt_buf <= receive_pc_data;
      if (r_d_state == D_PICK && w_disp_found)      r_tgt     <= w_disp_idx;
      if (r_d_state == D_SEND && w_tgt_accept)      r_disp_ptr <= ptr_inc(r_tgt);
    end
  end

  assign send_w_data = r_pkt_buf;

  // --------------------------------------------------------------------------
  // Collect side
  // --------------------------------------------------------------------------
  logic [0:0]                     r_r_state, w_r_next;
  logic [WORKER_RESULT_WIDTH-1:0] r_res_buf;
  logic [PTR_WIDTH-1:0]           r_src, r_coll_ptr;
  logic [PTR_WIDTH:0]             w_coll_pick;
  logic                           w_coll_found;
  logic [PTR_WIDTH-1:0]           w_coll_idx;
  logic [WORKER_RESULT_WIDTH-1:0] w_sel_data;

  assign w_coll_pick  = rr_pick(receive_w_valid, r_coll_ptr);
  assign w_coll_found = w_coll_pick[PTR_WIDTH];
  assign w_coll_idx   = w_coll_pick[PTR_WIDTH-1:0];
  assign w_sel_data   = WORKER_RESULT_WIDTH'(receive_w_data >> (w_coll_idx * WORKER_RESULT_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_r_state <= R_IDLE;
    else     r_r_state <= w_r_next;
  end

  always_comb begin
    w_r_next = r_r_state;
    case (r_r_state)
      R_IDLE:  if (w_coll_found)  w_r_next = R_OUT;
      R_OUT:   if (send_wr_ready) w_r_next = R_IDLE;
      default: w_r_next = R_IDLE;
    endcase
  end

  // The accept is combinational on the workers' valids; it is gated with
  // rst so that no ready appears while the block is held in reset.
  always_comb begin
    receive_w_ready = '0;
    if (r_r_state == R_IDLE && w_coll_found && !rst) receive_w_ready = c_ONE << w_coll_idx;
    send_wr_valid = (r_r_state == R_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_buf  <= '0;
      r_src      <= '0;
      r_coll_ptr <= '0;
    end else begin
      if (r_r_state == R_IDLE && w_coll_found) begin
        r_res_buf <= w_sel_data;
        r_src     <= w_coll_idx;
      end
      if (r_r_state == R_OUT && send_wr_ready) r_coll_ptr <= ptr_inc(r_src);
    end
  end

  assign send_wr_data = r_res_buf;

endmodule
`default_nettype wire

// File: tb/tb_worker_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_worker_scheduler
//  Purpose  : Directed self-checking bench for worker_scheduler with four
//             workers: reset, round-robin dispatch, busy-worker skip, collect
//             fairness, back-pressure and mid-operation reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_worker_scheduler;

  localparam int PW  = 32;
  localparam int WRW = 40;
  localparam int NW  = 4;
  localparam int PTW = 3;

  logic              clk;
  logic              rst;
  logic              receive_pc_valid;
  logic              receive_pc_ready;
  logic [PW-1:0]     receive_pc_data;
  logic [NW-1:0]     send_w_valid;
  logic [NW-1:0]     send_w_ready;
  logic [PW-1:0]     send_w_data;
  logic [NW-1:0]     receive_w_valid;
  logic [NW-1:0]     receive_w_ready;
  logic [NW*WRW-1:0] receive_w_data;
  logic              send_wr_valid;
  logic              send_wr_ready;
  logic [WRW-1:0]    send_wr_data;

  int passes = 0;
  int total  = 0;

  worker_scheduler #(
    .PACKET_WIDTH        (PW),
    .WORKER_RESULT_WIDTH (WRW),
    .NUM_WORKERS         (NW),
    .PTR_WIDTH           (PTW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .receive_pc_valid (receive_pc_valid),
    .receive_pc_ready (receive_pc_ready),
    .receive_pc_data  (receive_pc_data),
    .send_w_valid     (send_w_valid),
    .send_w_ready     (send_w_ready),
    .send_w_data      (send_w_data),
    .receive_w_valid  (receive_w_valid),
    .receive_w_ready  (receive_w_ready),
    .receive_w_data   (receive_w_data),
    .send_wr_valid    (send_wr_valid),
    .send_wr_ready    (send_wr_ready),
    .send_wr_data     (send_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result word that worker i presents.
  function automatic logic [WRW-1:0] res(input int i);
    return {3'b010, 16'hdead, 16'h0f0f, 5'(i)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to a point 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one packet and hold it until the scheduler takes it.
  task automatic pc_push(input logic [PW-1:0] d);
    receive_pc_valid = 1'b1;
    receive_pc_data  = d;
    for (int n = 0; n < 20 && !receive_pc_ready; n++) tick();
    check("pc_ready_wait", 64'(receive_pc_ready), 64'd1);
    tick();
    receive_pc_valid = 1'b0;
  endtask

  // Wait for the worker offer, compare target and data, let it complete.
  task automatic expect_dispatch(input string tag, input logic [NW-1:0] oh, input logic [PW-1:0] d);
    for (int n = 0; n < 20 && send_w_valid == '0; n++) tick();
    check({tag, "_tgt"}, 64'(send_w_valid), 64'(oh));
    check({tag, "_data"}, 64'(send_w_data), 64'(d));
    tick();
    check({tag, "_drop"}, 64'(send_w_valid), 64'd0);
  endtask

  initial begin
    rst              = 1'b1;
    receive_pc_valid = 1'b0;
    receive_pc_data  = '0;
    send_w_ready     = '0;
    receive_w_valid  = 4'b1111;   // must not leak through as ready in reset
    send_wr_ready    = 1'b0;
    for (int i = 0; i < NW; i++) receive_w_data[i*WRW +: WRW] = res(i);

    // ---- 1: reset ---------------------------------------------------------
    tick();
    tick();
    check("rst_pc_ready", 64'(receive_pc_ready), 64'd0);
    check("rst_w_valid",  64'(send_w_valid),     64'd0);
    check("rst_w_ready",  64'(receive_w_ready),  64'd0);
    check("rst_wr_valid", 64'(send_wr_valid),    64'd0);
    check("rst_w_data",   64'(send_w_data),      64'd0);
    check("rst_wr_data",  64'(send_wr_data),     64'd0);
    receive_w_valid = '0;
    rst = 1'b0;
    #1;
    check("rel_pc_ready0", 64'(receive_pc_ready), 64'd0);
    tick();
    tick();
    check("rel_pc_ready1", 64'(receive_pc_ready), 64'd1);

    // ---- 2: round-robin dispatch, all workers ready ---------------------
    send_w_ready = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      pc_push(32'hdead_beef + 32'(p));
      expect_dispatch("rr", 4'b0001 << (p % 4), 32'hdead_beef + 32'(p));
    end

    // ---- 3: skip busy workers (fresh reset puts disp_ptr at 0) -----------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    send_w_ready = 4'b0100;
    pc_push(32'h1234_5678);
    expect_dispatch("skip", 4'b0100, 32'h1234_5678);
    send_w_ready = 4'b0000;
    pc_push(32'hcafe_f00d);
    for (int n = 0; n < 5; n++) begin
      check("hold_w_valid",  64'(send_w_valid),     64'd0);
      check("hold_pc_ready", 64'(receive_pc_ready), 64'd0);
      tick();
    end
    send_w_ready = 4'b1111;   // disp_ptr is now 3, so worker 3 wins
    expect_dispatch("after_skip", 4'b1000, 32'hcafe_f00d);

    // ---- 4: collect fairness ---------------------------------------------
    send_wr_ready   = 1'b1;
    receive_w_valid = 4'b1111;
    #1;
    check("coll_ready0", 64'(receive_w_ready), 64'(4'b0001));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("coll_valid", 64'(send_wr_valid),   64'd1);
      check("coll_data",  64'(send_wr_data),    64'(res(i % 4)));
      check("coll_out_rdy", 64'(receive_w_ready), 64'd0);
      tick();
      check("coll_gap",   64'(send_wr_valid),   64'd0);
    end
    receive_w_valid = '0;     // coll_ptr is now 1

    // ---- 5: back-pressure ------------------------------------------------
    send_wr_ready   = 1'b0;
    receive_w_valid = 4'b0101;
    tick();
    for (int n = 0; n < 10; n++) begin
      check("bp_data",  64'(send_wr_data),    64'(res(2)));
      check("bp_ready", 64'(receive_w_ready), 64'd0);
      tick();
    end
    check("bp_valid", 64'(send_wr_valid), 64'd1);
    send_wr_ready = 1'b1;
    tick();
    tick();
    check("bp_next_valid", 64'(send_wr_valid), 64'd1);
    check("bp_next_data",  64'(send_wr_data),  64'(res(0)));
    send_wr_ready   = 1'b0;
    receive_w_valid = '0;

    // ---- 6: mid-operation reset ----------------------------------------
    send_w_ready = 4'b0000;
    pc_push(32'h5a5a_a5a5);
    send_w_ready = 4'b0010;   // disp_ptr is 0; only worker 1 ready
    tick();
    send_w_ready = 4'b0000;
    check("pre_w_valid",  64'(send_w_valid),  64'(4'b0010));
    check("pre_wr_valid", 64'(send_wr_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_w_valid",  64'(send_w_valid),     64'd0);
    check("mid_w_data",   64'(send_w_data),      64'd0);
    check("mid_wr_valid", 64'(send_wr_valid),    64'd0);
    check("mid_wr_data",  64'(send_wr_data),     64'd0);
    check("mid_pc_ready", 64'(receive_pc_ready), 64'd0);
    tick();
    rst           = 1'b0;
    send_w_ready  = 4'b1111;
    send_wr_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("post_w_valid",  64'(send_w_valid),  64'd0);
      check("post_wr_valid", 64'(send_wr_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
